tlul_host_arb2: RTL and testbench
=================================

# tlul_host_arb2

Two-host TL-UL arbiter that shares the single upstream port of the peripheral crossbar between the instruction-fetch host (h0) and the load/store host (h1). It grants the A channel round-robin and holds the grant while a request is stalled. It records the granted host of every accepted request in an in-order ID FIFO and steers each D-channel response back to its issuing host. Sits between the core's two TL-UL host ports and the crossbar host input.

## Interface
- MaxOutstanding, 4: depth of the response-steering ID FIFO; legal range 1..16.
- CntW, $clog2(MaxOutstanding+1): width of the outstanding counter (derived, not overridable).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- tl_h0_i  in  tl_h2d_t  request from instruction-fetch host.
- tl_h0_o  out  tl_d2h_t  response to instruction-fetch host.
- tl_h1_i  in  tl_h2d_t  request from LSU host.
- tl_h1_o  out  tl_d2h_t  response to LSU host.
- tl_dev_o  out  tl_h2d_t  request to crossbar host port.
- tl_dev_i  in  tl_d2h_t  response from crossbar host port.
- outstanding_o  out  CntW  number of accepted, unanswered requests.
- spurious_rsp_o  out  1  one-cycle pulse: D beat received with FIFO empty.

## Operation
- State:
  - rr_q (1 b): host holding priority; reset 0, so h0 has priority.
  - lock_q (1 b), lock_id_q (1 b): grant hold; reset 0.
  - ID FIFO: MaxOutstanding entries of 1 b, with rd/wr pointers and count; reset empty.
  - spurious_rsp_o: registered; reset 0.
- Grant:
  - If lock_q = 1, grant lock_id_q.
  - Otherwise, if both a_valid are high, grant rr_q.
  - Otherwise, grant whichever host has a_valid high.
- Full gate: when count = MaxOutstanding, force tl_dev_o.a_valid = 0 and both host a_ready = 0.
- A forwarding: all A fields of the granted host pass unmodified to tl_dev_o. The granted host's a_ready = tl_dev_i.a_ready, gated by full. The non-granted host's a_ready = 0.
- A handshake (tl_dev_o.a_valid & tl_dev_i.a_ready):
  - push the granted id;
  - set rr_q to the other host;
  - clear lock_q.
- Stall (tl_dev_o.a_valid & ~tl_dev_i.a_ready): set lock_q = 1 and lock_id_q = grant. This keeps a_valid and the payload stable per TL-UL.
- D steering:
  - head = FIFO output.
  - tl_h<head>_o.d_* = tl_dev_i.d_*, and tl_h<head>_o.d_valid = tl_dev_i.d_valid.
  - The other host sees d_valid = 0.
  - tl_dev_o.d_ready = the head host's d_ready.
- D handshake: pops the FIFO.
- Empty FIFO with tl_dev_i.d_valid = 1:
  - tl_dev_o.d_ready = 1 (beat dropped);
  - no host sees d_valid;
  - spurious_rsp_o pulses on the next cycle.
- Push and pop in the same cycle: count unchanged and pointers both advance. The full gate uses the registered count, so there is no bypass.
- outstanding_o = count.

## Timing
- A path is combinational, zero added latency: host a_valid reaches tl_dev_o.a_valid in the same cycle.
- D path is combinational, zero added latency.
- Each host's tl_h*_o.a_ready is combinational from tl_dev_i.a_ready and the arbiter state.
- Throughput: one A beat per cycle while not full. Under continuous contention, grants alternate h0, h1, h0, …
- Reset mid-operation: all state clears asynchronously; in-flight responses after reset release are treated as spurious.
- Outputs in reset:
  - host d_valid = 0;
  - spurious_rsp_o = 0;
  - outstanding_o = 0;
  - tl_dev_o.a_valid follows host a_valid, with the grant taken from reset state.

## Test plan
- Single host: h1 issues 3 Gets to GPIO with the device ready. Required: 3 beats forwarded in consecutive cycles, outstanding_o reaches 3, responses return only on tl_h1_o, and h0 never sees d_valid.
- Contention: h0 and h1 both request continuously with the device always ready. Required: grant order h0, h1, h0, h1 and 1:1 acceptance counts over 100 cycles.
- Stall lock: h1 is granted with the device a_ready low for 5 cycles, and h0 raises a_valid during the stall. Required: tl_dev_o stays on h1's payload for all 5 cycles and h0 is granted in the first cycle after the handshake.
- Full: MaxOutstanding = 4 with responses withheld. Required: the 5th request sees a_ready = 0. After one D handshake, the 5th request is accepted the next cycle.
- Ordering: issue h0, h1, h0, then return 3 D beats with d_source echoed. Required: beats route to h0, h1, h0 in that order, and the h1 d_ready = 0 back-pressure case stalls tl_dev_o.d_ready.
- Spurious: inject d_valid with FIFO empty. Required: beat consumed (d_ready = 1), no host sees d_valid, and spurious_rsp_o is high for exactly 1 cycle.

Source files
------------

// File: rtl/tlul_host_arb2.sv
// Two-host TL-UL arbiter: round-robin A-channel grant with stall lock,
// in-order ID FIFO steering D-channel responses back to the issuing host.

package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_arb2
    import tlul_pkg::*;
#(
    parameter int  MaxOutstanding = 4,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h0_i,
    output tl_d2h_t         tl_h0_o,
    input  tl_h2d_t         tl_h1_i,
    output tl_d2h_t         tl_h1_o,
    output tl_h2d_t         tl_dev_o,
    input  tl_d2h_t         tl_dev_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            spurious_rsp_o
);
    localparam int              PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic                      rr_q;
    logic                      lock_q;
    logic                      lock_id_q;
    logic [MaxOutstanding-1:0] id_fifo_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [CntW-1:0]           cnt_q;
    logic                      spurious_q;

    logic gnt;
    logic full;
    logic empty;
    logic head;
    logic dev_a_valid;
    logic dev_d_ready;
    logic push;
    logic pop;

    assign full  = (cnt_q == FullCnt);
    assign empty = (cnt_q == '0);
    assign head  = id_fifo_q[rd_ptr_q];

    // Grant select: a stalled request keeps its grant, otherwise round-robin on contention.
    always_comb begin
        if (lock_q) begin
            gnt = lock_id_q;
        end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
            gnt = rr_q;
        end else begin
            gnt = tl_h1_i.a_valid;
        end
    end

    assign dev_a_valid = (gnt ? tl_h1_i.a_valid : tl_h0_i.a_valid) & ~full;
    // With nothing outstanding the beat has no owner, so accept and drop it.
    assign dev_d_ready = empty ? 1'b1 : (head ? tl_h1_i.d_ready : tl_h0_i.d_ready);
    assign push        = dev_a_valid & tl_dev_i.a_ready;
    assign pop         = tl_dev_i.d_valid & dev_d_ready & ~empty;

    // Channel muxing: A payload from the granted host, D payload broadcast, valids/readies steered.
    always_comb begin
        tl_dev_o         = gnt ? tl_h1_i : tl_h0_i;
        tl_dev_o.a_valid = dev_a_valid;
        tl_dev_o.d_ready = dev_d_ready;

        tl_h0_o          = tl_dev_i;
        tl_h0_o.a_ready  = ~gnt & ~full & tl_dev_i.a_ready;
        tl_h0_o.d_valid  = tl_dev_i.d_valid & ~empty & ~head;

        tl_h1_o          = tl_dev_i;
        tl_h1_o.a_ready  = gnt & ~full & tl_dev_i.a_ready;
        tl_h1_o.d_valid  = tl_dev_i.d_valid & ~empty & head;
    end

    // Arbitration state: rotate priority on acceptance, lock the grant while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else if (push) begin
            rr_q      <= ~gnt;
            lock_q    <= 1'b0;
        end else if (dev_a_valid) begin
            lock_q    <= 1'b1;
            lock_id_q <= gnt;
        end
    end

    // ID FIFO: records the issuing host of each accepted request, popped by D handshakes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= gnt;
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Flag a response that arrived with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= tl_dev_i.d_valid & empty;
        end
    end

    assign outstanding_o  = cnt_q;
    assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Bench for tlul_host_arb2: directed vector table, randomized run against a
// queue-based reference model, mid-operation reset and sustained contention.

module tb_tlul_host_arb2;
    import tlul_pkg::*;

    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    tl_h2d_t       h0_i, h1_i, dev_o;
    tl_d2h_t       h0_o, h1_o, dev_i;
    logic [CW-1:0] outst;
    logic          spur;

    int n_cmp = 0;
    int n_bad = 0;

    tlul_host_arb2 #(.MaxOutstanding(MAXO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tl_h0_i        (h0_i),
        .tl_h0_o        (h0_o),
        .tl_h1_i        (h1_i),
        .tl_h1_o        (h1_o),
        .tl_dev_o       (dev_o),
        .tl_dev_i       (dev_i),
        .outstanding_o  (outst),
        .spurious_rsp_o (spur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       h0_av, h1_av, dev_ar, dev_dv;
        logic [7:0] dsrc;
        logic       h0_dr, h1_dr;
        logic       e_av;
        logic [7:0] e_asrc;
        logic       e_h0ar, e_h1ar, e_h0dv, e_h1dv, e_ddr;
        int         e_out;
        logic       e_spur;
    } vec_t;

    function automatic vec_t mk(input logic a0, a1, ar, dv, input logic [7:0] ds,
                                input logic r0, r1, eav, input logic [7:0] easrc,
                                input logic e0ar, e1ar, e0dv, e1dv, eddr,
                                input int eout, input logic esp);
        vec_t v;
        v.h0_av = a0; v.h1_av = a1; v.dev_ar = ar; v.dev_dv = dv; v.dsrc = ds;
        v.h0_dr = r0; v.h1_dr = r1; v.e_av = eav; v.e_asrc = easrc;
        v.e_h0ar = e0ar; v.e_h1ar = e1ar; v.e_h0dv = e0dv; v.e_h1dv = e1dv;
        v.e_ddr = eddr; v.e_out = eout; v.e_spur = esp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // h0 always carries source 0x10, h1 source 0x21 (GPIO Get), so the forwarded
    // a_source identifies the granted host.
    task automatic drive(input logic a0, a1, ar, dv, input logic [7:0] ds, input logic r0, r1);
        h0_i = '0;
        h0_i.a_valid = a0; h0_i.a_opcode = 3'd4; h0_i.a_source = 8'h10;
        h0_i.a_address = 32'h0000_1000; h0_i.a_mask = 4'hf; h0_i.d_ready = r0;
        h1_i = '0;
        h1_i.a_valid = a1; h1_i.a_opcode = 3'd4; h1_i.a_source = 8'h21;
        h1_i.a_address = 32'h4001_0000; h1_i.a_mask = 4'hf; h1_i.d_ready = r1;
        dev_i = '0;
        dev_i.a_ready = ar; dev_i.d_valid = dv; dev_i.d_source = ds;
        dev_i.d_data = {24'h0, ds};
    endtask

    vec_t vt[$];

    // reference model state
    bit m_rr, m_lock, m_lid, m_spur;
    bit q[$];
    bit p0, p1, g, full, emp, hd, eav, e0ar, e1ar, e0dv, e1dv, eddr, ar, dv, r0, r1;
    int n0, n1;

    initial begin
        // h0av h1av ar dv dsrc r0 r1 | av asrc h0ar h1ar h0dv h1dv ddr out spur
        // single host h1: three Gets then three responses
        vt.push_back(mk(0,1,1,0,8'h00,1,1, 1,8'h21,0,1,0,0,1,0,0));
        vt.push_back(mk(0,1,1,0,8'h00,1,1, 1,8'h21,0,1,0,0,1,1,0));
        vt.push_back(mk(0,1,1,0,8'h00,1,1, 1,8'h21,0,1,0,0,1,2,0));
        vt.push_back(mk(0,0,1,1,8'h21,1,1, 0,8'h00,1,0,0,1,1,3,0));
        vt.push_back(mk(0,0,1,1,8'h21,1,1, 0,8'h00,1,0,0,1,1,2,0));
        vt.push_back(mk(0,0,1,1,8'h21,1,1, 0,8'h00,1,0,0,1,1,1,0));
        vt.push_back(mk(0,0,1,0,8'h00,1,1, 0,8'h00,1,0,0,0,1,0,0));
        // stall lock: h1 stalled 5 cycles, h0 joins during the stall
        vt.push_back(mk(0,1,0,0,8'h00,1,1, 1,8'h21,0,0,0,0,1,0,0));
        vt.push_back(mk(1,1,0,0,8'h00,1,1, 1,8'h21,0,0,0,0,1,0,0));
        vt.push_back(mk(1,1,0,0,8'h00,1,1, 1,8'h21,0,0,0,0,1,0,0));
        vt.push_back(mk(1,1,0,0,8'h00,1,1, 1,8'h21,0,0,0,0,1,0,0));
        vt.push_back(mk(1,1,0,0,8'h00,1,1, 1,8'h21,0,0,0,0,1,0,0));
        vt.push_back(mk(1,1,1,0,8'h00,1,1, 1,8'h21,0,1,0,0,1,0,0));
        vt.push_back(mk(1,1,1,0,8'h00,1,1, 1,8'h10,1,0,0,0,1,1,0));
        // contention fills the FIFO
        vt.push_back(mk(1,1,1,0,8'h00,1,1, 1,8'h21,0,1,0,0,1,2,0));
        vt.push_back(mk(1,1,1,0,8'h00,1,1, 1,8'h10,1,0,0,0,1,3,0));
        // full: request blocked, one D handshake, accepted next cycle
        vt.push_back(mk(1,1,1,0,8'h00,1,1, 0,8'h00,0,0,0,0,1,4,0));
        vt.push_back(mk(1,1,1,1,8'h21,1,1, 0,8'h00,0,0,0,1,1,4,0));
        vt.push_back(mk(1,1,1,0,8'h00,1,1, 1,8'h21,0,1,0,0,1,3,0));
        // ordered drain h0,h1,h0,h1 with h1 back-pressure
        vt.push_back(mk(0,0,1,1,8'h10,1,0, 0,8'h00,0,0,1,0,1,4,0));
        vt.push_back(mk(0,0,1,1,8'h21,1,0, 0,8'h00,1,0,0,1,0,3,0));
        vt.push_back(mk(0,0,1,1,8'h21,1,1, 0,8'h00,1,0,0,1,1,3,0));
        vt.push_back(mk(0,0,1,1,8'h10,1,1, 0,8'h00,1,0,1,0,1,2,0));
        vt.push_back(mk(0,0,1,1,8'h21,1,1, 0,8'h00,1,0,0,1,1,1,0));
        // spurious beat with FIFO empty
        vt.push_back(mk(0,0,1,1,8'h55,0,0, 0,8'h00,1,0,0,0,1,0,0));
        vt.push_back(mk(0,0,1,0,8'h00,0,0, 0,8'h00,1,0,0,0,1,0,1));
        vt.push_back(mk(0,0,1,0,8'h00,0,0, 0,8'h00,1,0,0,0,1,0,0));

        // reset state
        rst_n = 1'b0;
        drive(1,0,1,1,8'h33,1,1);
        #3;
        chk("rst_dev_av",  dev_o.a_valid, 1);
        chk("rst_asrc",    dev_o.a_source, 8'h10);
        chk("rst_out",     outst, 0);
        chk("rst_spur",    spur, 0);
        chk("rst_h0dv",    h0_o.d_valid, 0);
        chk("rst_h1dv",    h1_o.d_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        foreach (vt[i]) begin
            drive(vt[i].h0_av, vt[i].h1_av, vt[i].dev_ar, vt[i].dev_dv, vt[i].dsrc,
                  vt[i].h0_dr, vt[i].h1_dr);
            #1;
            chk($sformatf("v%0d_av", i),   dev_o.a_valid,  vt[i].e_av);
            if (vt[i].e_av) chk($sformatf("v%0d_asrc", i), dev_o.a_source, vt[i].e_asrc);
            chk($sformatf("v%0d_h0ar", i), h0_o.a_ready,   vt[i].e_h0ar);
            chk($sformatf("v%0d_h1ar", i), h1_o.a_ready,   vt[i].e_h1ar);
            chk($sformatf("v%0d_h0dv", i), h0_o.d_valid,   vt[i].e_h0dv);
            chk($sformatf("v%0d_h1dv", i), h1_o.d_valid,   vt[i].e_h1dv);
            chk($sformatf("v%0d_ddr", i),  dev_o.d_ready,  vt[i].e_ddr);
            chk($sformatf("v%0d_out", i),  outst,          vt[i].e_out);
            chk($sformatf("v%0d_spur", i), spur,           vt[i].e_spur);
            if (vt[i].e_h0dv) chk($sformatf("v%0d_h0ds", i), h0_o.d_source, vt[i].dsrc);
            if (vt[i].e_h1dv) chk($sformatf("v%0d_h1ds", i), h1_o.d_source, vt[i].dsrc);
            @(negedge clk);
        end

        // randomized run against the reference model (state left idle by the table)
        m_rr = 0; m_lock = 0; m_lid = 0; m_spur = 0; q.delete();
        p0 = 0; p1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0) p0 = ($urandom % 3) == 0;
            if (!p1) p1 = ($urandom % 3) == 0;
            ar = ($urandom % 4) != 0;
            dv = ($urandom % 2) == 0;
            r0 = ($urandom % 4) != 0;
            r1 = ($urandom % 4) != 0;
            drive(p0, p1, ar, dv, 8'($urandom), r0, r1);
            #1;
            g    = m_lock ? m_lid : ((p0 && p1) ? m_rr : p1);
            full = q.size() == MAXO;
            emp  = q.size() == 0;
            hd   = emp ? 1'b0 : q[0];
            eav  = (g ? p1 : p0) && !full;
            e0ar = !g && !full && ar;
            e1ar = g && !full && ar;
            e0dv = dv && !emp && !hd;
            e1dv = dv && !emp && hd;
            eddr = emp ? 1'b1 : (hd ? r1 : r0);
            chk("rnd_av",   dev_o.a_valid, eav);
            if (eav) chk("rnd_asrc", dev_o.a_source, g ? 8'h21 : 8'h10);
            chk("rnd_h0ar", h0_o.a_ready, e0ar);
            chk("rnd_h1ar", h1_o.a_ready, e1ar);
            chk("rnd_h0dv", h0_o.d_valid, e0dv);
            chk("rnd_h1dv", h1_o.d_valid, e1dv);
            chk("rnd_ddr",  dev_o.d_ready, eddr);
            chk("rnd_out",  outst, q.size());
            chk("rnd_spur", spur, m_spur);
            m_spur = dv && emp;
            if (dv && eddr && !emp) void'(q.pop_front());
            if (eav && ar) begin
                q.push_back(g);
                m_rr = !g;
                m_lock = 0;
                if (g) p1 = 0; else p0 = 0;
            end else if (eav) begin
                m_lock = 1;
                m_lid = g;
            end
            @(negedge clk);
        end

        // reset mid-operation; in-flight response afterwards is spurious
        drive(0,1,1,0,8'h00,1,1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0,0,1,1,8'h21,1,1);
        #1;
        chk("mrst_out",  outst, 0);
        chk("mrst_spur", spur, 0);
        chk("mrst_h1dv", h1_o.d_valid, 0);
        chk("mrst_h0dv", h0_o.d_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_rel_h1dv", h1_o.d_valid, 0);
        chk("mrst_rel_ddr",  dev_o.d_ready, 1);
        @(negedge clk);
        #1;
        chk("mrst_rel_spur", spur, 1);
        @(negedge clk);

        // sustained contention with responses returning every cycle
        n0 = 0; n1 = 0;
        g = 0;
        for (int c = 0; c < 100; c++) begin
            drive(1,1,1,1,8'h00,1,1);
            #1;
            chk("cont_grant", dev_o.a_source, g ? 8'h21 : 8'h10);
            if (dev_o.a_valid && dev_o.a_source == 8'h10 && h0_o.a_ready) n0++;
            if (dev_o.a_valid && dev_o.a_source == 8'h21 && h1_o.a_ready) n1++;
            g = !g;
            @(negedge clk);
        end
        chk("cont_n0", n0, 50);
        chk("cont_n1", n1, 50);
        chk("cont_out", outst, 1);

        drive(0,0,1,0,8'h00,1,1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
